// File: rtl/usrt_bus_pkg.sv
// Shared constants for the USRT host bus slave: register-select codes,
// STATUS flag bit positions and the bus handshake state encoding.
package usrt_bus_pkg;

    localparam logic [1:0] ADDR_ST  = 2'b00;
    localparam logic [1:0] ADDR_TX  = 2'b01;
    localparam logic [1:0] ADDR_RX  = 2'b10;
    localparam logic [1:0] ADDR_RSV = 2'b11;

    localparam int TX_PEND = 0;
    localparam int RX_FULL = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } bus_state_e;

endpackage

// File: rtl/usrt_bus_ctrl.sv
// APB handshake sequencer: one registered ready pulse per transfer and a
// combinational commit strobe marking the edge on which the access takes effect.
module usrt_bus_ctrl (
    input  logic clk_i,
    input  logic rst_i,
    input  logic psel_i,
    input  logic penable_i,
    output logic pready_o,
    output logic commit_o
);
    import usrt_bus_pkg::*;

    bus_state_e state_q, state_d;
    logic       pready_q;

    // Next-state and commit decode; DONE parks until the host ends the transfer
    always_comb begin
        state_d  = state_q;
        commit_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (psel_i && penable_i) begin
                    state_d  = ST_ACCESS;
                    commit_o = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!penable_i || !psel_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and ready registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            pready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pready_q <= commit_o;
        end
    end

    assign pready_o = pready_q;

endmodule

// File: rtl/usrt_bus.sv
// USRT host bus slave: STATUS/TX/RX register file with address decode,
// driven by the usrt_bus_ctrl handshake sequencer.
module usrt_bus #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8
) (
    input  logic              i_Pclk,
    input  logic              i_Preset,
    input  logic              i_Psel,
    input  logic              i_Penable,
    input  logic              i_Pwrite,
    input  logic [DATA_W-1:0] i_Pwdata,
    input  logic [ADDR_W-1:0] i_Paddr,
    output logic [DATA_W-1:0] o_Prdata,
    output logic              o_Pready,
    output logic [DATA_W-1:0] o_Tx_Data,
    output logic              o_Tx_Valid,
    input  logic              i_Tx_Done,
    input  logic [DATA_W-1:0] i_Rx_Data,
    input  logic              i_Rx_Valid
);
    import usrt_bus_pkg::*;

    logic              commit_s;
    logic [1:0]        sel_s;
    logic              wr_st_s, wr_tx_s, rd_s, rd_rx_s;
    logic [DATA_W-1:0] status_s, rd_val_s;
    logic              unused_addr_s;

    logic [DATA_W-3:0] sw_q, sw_d;
    logic              tx_pend_q, tx_pend_d;
    logic              rx_full_q, rx_full_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic              tx_valid_q, tx_valid_d;

    usrt_bus_ctrl u_ctrl (
        .clk_i     (i_Pclk),
        .rst_i     (i_Preset),
        .psel_i    (i_Psel),
        .penable_i (i_Penable),
        .pready_o  (o_Pready),
        .commit_o  (commit_s)
    );

    assign sel_s         = i_Paddr[ADDR_W-1 -: 2];
    assign unused_addr_s = ^i_Paddr[ADDR_W-3:0];
    assign wr_st_s       = commit_s &  i_Pwrite & (sel_s == ADDR_ST);
    assign wr_tx_s       = commit_s &  i_Pwrite & (sel_s == ADDR_TX);
    assign rd_s          = commit_s & ~i_Pwrite;
    assign rd_rx_s       = rd_s & (sel_s == ADDR_RX);

    // STATUS image and read-data mux; reserved slot reads zero
    always_comb begin
        status_s                = '0;
        status_s[DATA_W-1:2]    = sw_q;
        status_s[TX_PEND]       = tx_pend_q;
        status_s[RX_FULL]       = rx_full_q;
        case (sel_s)
            ADDR_ST: rd_val_s = status_s;
            ADDR_TX: rd_val_s = tx_q;
            ADDR_RX: rd_val_s = rx_q;
            default: rd_val_s = '0;
        endcase
    end

    // Register next-state; a TX write beats i_Tx_Done, i_Rx_Valid beats a clearing RX read
    always_comb begin
        tx_valid_d = wr_tx_s;
        if (wr_st_s) begin
            sw_d = i_Pwdata[DATA_W-1:2];
        end else begin
            sw_d = sw_q;
        end
        if (wr_tx_s) begin
            tx_d      = i_Pwdata;
            tx_pend_d = 1'b1;
        end else if (i_Tx_Done) begin
            tx_d      = tx_q;
            tx_pend_d = 1'b0;
        end else begin
            tx_d      = tx_q;
            tx_pend_d = tx_pend_q;
        end
        if (i_Rx_Valid) begin
            rx_d      = i_Rx_Data;
            rx_full_d = 1'b1;
        end else if (rd_rx_s) begin
            rx_d      = rx_q;
            rx_full_d = 1'b0;
        end else begin
            rx_d      = rx_q;
            rx_full_d = rx_full_q;
        end
        if (rd_s) begin
            prdata_d = rd_val_s;
        end else begin
            prdata_d = prdata_q;
        end
    end

    // Register file state
    always_ff @(posedge i_Pclk) begin
        if (i_Preset) begin
            sw_q       <= '0;
            tx_pend_q  <= 1'b0;
            rx_full_q  <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
            prdata_q   <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            sw_q       <= sw_d;
            tx_pend_q  <= tx_pend_d;
            rx_full_q  <= rx_full_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            prdata_q   <= prdata_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign o_Prdata   = prdata_q;
    assign o_Tx_Data  = tx_q;
    assign o_Tx_Valid = tx_valid_q;

endmodule

// File: tb/tb_usrt_bus.sv
// Self-checking bench for usrt_bus: directed vector table, hand-written
// collision/reset sequences and random transfers against a register-level model.
module tb_usrt_bus;

    logic        clk = 1'b0;
    logic        preset, psel, penable, pwrite, tx_done, rx_valid;
    logic [7:0]  pwdata, rx_data;
    logic [31:0] paddr;
    logic [7:0]  prdata, tx_data;
    logic        pready, tx_valid;

    int n_tests = 0;
    int n_fail  = 0;

    // register-level model of the host-visible state
    logic [5:0] m_sw;
    logic [7:0] m_tx, m_rx, m_prd;
    bit         m_pend, m_full;

    typedef struct {
        bit         wr;
        logic [1:0] sel;
        logic [7:0] wd;
        logic [7:0] exp_rd;
    } vec_t;
    vec_t tbl[12];

    usrt_bus #(.ADDR_W(32), .DATA_W(8)) dut (
        .i_Pclk     (clk),
        .i_Preset   (preset),
        .i_Psel     (psel),
        .i_Penable  (penable),
        .i_Pwrite   (pwrite),
        .i_Pwdata   (pwdata),
        .i_Paddr    (paddr),
        .o_Prdata   (prdata),
        .o_Pready   (pready),
        .o_Tx_Data  (tx_data),
        .o_Tx_Valid (tx_valid),
        .i_Tx_Done  (tx_done),
        .i_Rx_Data  (rx_data),
        .i_Rx_Valid (rx_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [1:0] sel);
        case (sel)
            2'b00:   return {m_sw, m_full, m_pend};
            2'b01:   return m_tx;
            2'b10:   return m_rx;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_sw = 6'd0; m_tx = 8'h00; m_rx = 8'h00; m_prd = 8'h00;
        m_pend = 1'b0; m_full = 1'b0;
    endtask

    // one complete APB transfer; optional Rx/TxDone strobes land on the commit edge
    task automatic xfer(input bit wr, input logic [1:0] sel, input logic [7:0] wd,
                        input bit rxc, input logic [7:0] rxb, input bit dnc,
                        output logic [7:0] rd);
        logic [7:0] exp_rd;
        int lat, np, nv;
        exp_rd = wr ? m_prd : model_read(sel);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; pwdata = wd;
        paddr = {sel, 30'($urandom)};
        @(negedge clk);
        penable = 1'b1;
        if (rxc) begin rx_valid = 1'b1; rx_data = rxb; end
        if (dnc) tx_done = 1'b1;
        lat = 0; np = 0; nv = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            rx_valid = 1'b0; tx_done = 1'b0;
            if (pready) begin np++; if (lat == 0) lat = c; end
            if (tx_valid) nv++;
        end
        rd = prdata;
        psel = 1'b0; penable = 1'b0;
        // model update after the access
        if (wr && sel == 2'b00) m_sw = wd[7:2];
        if (dnc) m_pend = 1'b0;
        if (wr && sel == 2'b01) begin m_tx = wd; m_pend = 1'b1; end
        if (!wr && sel == 2'b10) m_full = 1'b0;
        if (rxc) begin m_rx = rxb; m_full = 1'b1; end
        m_prd = exp_rd;
        if (lat == 0) check("pready_timeout", 32'd0, 32'd1);
        else check("pready_latency", lat, 32'd1);
        check("pready_pulses", np, 32'd1);
        check("tx_valid_pulses", nv, (wr && sel == 2'b01) ? 32'd1 : 32'd0);
        check("tx_data", tx_data, m_tx);
        check("prdata", rd, exp_rd);
    endtask

    task automatic pulse_rx(input logic [7:0] b);
        @(negedge clk); rx_valid = 1'b1; rx_data = b;
        @(negedge clk); rx_valid = 1'b0;
        m_rx = b; m_full = 1'b1;
    endtask

    task automatic pulse_done();
        @(negedge clk); tx_done = 1'b1;
        @(negedge clk); tx_done = 1'b0;
        m_pend = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        pwdata = 8'h00; paddr = 32'h0; tx_done = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        model_reset();

        tbl[0]  = '{1'b0, 2'b00, 8'h00, 8'h00};
        tbl[1]  = '{1'b0, 2'b01, 8'h00, 8'h00};
        tbl[2]  = '{1'b0, 2'b10, 8'h00, 8'h00};
        tbl[3]  = '{1'b1, 2'b00, 8'hCA, 8'h00};
        tbl[4]  = '{1'b0, 2'b00, 8'h00, 8'hC8};
        tbl[5]  = '{1'b1, 2'b11, 8'hFF, 8'hC8};
        tbl[6]  = '{1'b0, 2'b11, 8'h00, 8'h00};
        tbl[7]  = '{1'b1, 2'b10, 8'h77, 8'h00};
        tbl[8]  = '{1'b0, 2'b10, 8'h00, 8'h00};
        tbl[9]  = '{1'b1, 2'b01, 8'h3C, 8'h00};
        tbl[10] = '{1'b0, 2'b01, 8'h00, 8'h3C};
        tbl[11] = '{1'b0, 2'b00, 8'h00, 8'hC9};

        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("rst_pready", pready, 32'd0);
        check("rst_prdata", prdata, 32'h00);
        check("rst_tx_data", tx_data, 32'h00);
        check("rst_tx_valid", tx_valid, 32'd0);
        preset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            xfer(tbl[i].wr, tbl[i].sel, tbl[i].wd, 1'b0, 8'h00, 1'b0, rd);
            check($sformatf("tbl%0d_prdata", i), rd, tbl[i].exp_rd);
        end

        pulse_done();
        xfer(1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0, rd); check("st_after_done", rd, 32'hC8);
        xfer(1'b1, 2'b01, 8'hB3, 1'b0, 8'h00, 1'b0, rd); check("tx_b3", tx_data, 32'hB3);
        xfer(1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0, rd); check("st_pend", rd, 32'hC9);
        pulse_done();
        xfer(1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0, rd); check("st_pend_clr", rd, 32'hC8);
        pulse_rx(8'h5A);
        xfer(1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0, rd); check("st_rxfull", rd, 32'hCA);
        xfer(1'b0, 2'b10, 8'h00, 1'b0, 8'h00, 1'b0, rd); check("rx_5a", rd, 32'h5A);
        xfer(1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0, rd); check("st_rx_clr", rd, 32'hC8);
        // collisions: TX write with TxDone, RX read with RxValid
        xfer(1'b1, 2'b01, 8'h44, 1'b0, 8'h00, 1'b1, rd);
        xfer(1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0, rd); check("st_wr_done_coll", rd, 32'hC9);
        xfer(1'b0, 2'b10, 8'h00, 1'b1, 8'h99, 1'b0, rd); check("rx_old_on_coll", rd, 32'h5A);
        xfer(1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0, rd); check("st_rd_rx_coll", rd, 32'hCB);
        xfer(1'b0, 2'b10, 8'h00, 1'b0, 8'h00, 1'b0, rd); check("rx_99", rd, 32'h99);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 7) == 0) pulse_rx(8'($urandom));
            if ($urandom_range(0, 7) == 0) pulse_done();
            xfer(1'($urandom), 2'($urandom), 8'($urandom),
                 ($urandom_range(0, 3) == 0), 8'($urandom),
                 ($urandom_range(0, 3) == 0), rd);
        end

        // reset while the transfer sits in ACCESS
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; pwdata = 8'h11; paddr = 32'h4000_0000;
        @(negedge clk); penable = 1'b1;
        @(negedge clk);
        check("pre_rst_pready", pready, 32'd1);
        preset = 1'b1;
        @(negedge clk);
        check("mid_rst_pready", pready, 32'd0);
        check("mid_rst_tx_valid", tx_valid, 32'd0);
        check("mid_rst_tx_data", tx_data, 32'h00);
        check("mid_rst_prdata", prdata, 32'h00);
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        model_reset();
        xfer(1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0, rd); check("post_rst_st", rd, 32'h00);
        xfer(1'b1, 2'b00, 8'hF0, 1'b0, 8'h00, 1'b0, rd);
        xfer(1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0, rd); check("post_rst_st_wr", rd, 32'hF0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
